icache_dm_fetch: RTL and testbench

//  Direct-mapped, read-only instruction cache between IF0 (PC generation) and IF1 (predecode/predict).

---
 rtl/icache_dm_fetch_if.sv | 31 +++
 rtl/icache_dm_fetch.sv | 125 ++++++++++++
 tb/tb_icache_dm_fetch.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/icache_dm_fetch_if.sv
// Fetch-side and memory-side signal bundle for icache_dm_fetch.
// slave = cache view, master = front end / memory view.
interface icache_dm_fetch_if #(
  parameter int WORD       = 32,
  parameter int LINE_WORDS = 4
);
  logic                       stall;
  logic                       flush;
  logic [WORD-1:0]            PC;
  logic                       pipeline_valid;
  logic                       memory_ready;
  logic [WORD*LINE_WORDS-1:0] data_from_mem;
  logic [WORD-1:0]            load_addr;
  logic                       memory_valid;
  logic                       pipeline_ready;
  logic [WORD-1:0]            inst;

  modport slave (
    input  stall, flush, PC, pipeline_valid,
    input  memory_ready, data_from_mem,
    output load_addr, memory_valid,
    output pipeline_ready, inst
  );

  modport master (
    output stall, flush, PC, pipeline_valid,
    output memory_ready, data_from_mem,
    input  load_addr, memory_valid,
    input  pipeline_ready, inst
  );
endinterface

// File: rtl/icache_dm_fetch.sv
// Direct-mapped read-only instruction cache for the IF0/IF1 pair.
// Hit returns the word one cycle after the PC; a miss refills a line.
module icache_dm_fetch #(
  parameter int          WORD       = 32,
  parameter int          LINE_WORDS = 4,
  parameter int          SETS       = 64,
  parameter logic [31:0] NOP_INST   = 32'h0340_0000
) (
  input logic              clk,
  input logic              rst,
  icache_dm_fetch_if.slave bus
);
  localparam int BYTE_W = $clog2(WORD / 8);
  localparam int WSEL_W = $clog2(LINE_WORDS);
  localparam int OFF_W  = BYTE_W + WSEL_W;
  localparam int IDX_W  = $clog2(SETS);
  localparam int TAG_W  = WORD - IDX_W - OFF_W;

  typedef enum logic [1:0] {
    LOOKUP,
    MISS,
    REFILL
  } state_t;

  state_t state, state_nx;

  logic [WORD-1:0]  req_pc;
  logic             req_valid;
  logic             cancel;
  logic [SETS-1:0]  valid;
  logic [TAG_W-1:0] tag_arr [SETS];
  logic [WORD-1:0]  data_arr [SETS][LINE_WORDS];

  logic [IDX_W-1:0]  idx;
  logic [WSEL_W-1:0] wsel;
  logic [TAG_W-1:0]  tag;
  logic [WORD-1:0]   word;
  logic              hit;
  logic              live;
  logic              fill;
  logic              cap;
  logic              ready;
  logic              mem_valid;
  logic [WORD-1:0]   inst;

  assign idx  = req_pc[OFF_W +: IDX_W];
  assign wsel = req_pc[BYTE_W +: WSEL_W];
  assign tag  = req_pc[WORD-1 -: TAG_W];
  assign word = data_arr[idx][wsel];
  assign hit  = valid[idx] & (tag_arr[idx] == tag);
  assign live = req_valid & ~cancel;
  assign fill = (state == MISS) & bus.memory_ready;

  // A flush only redirects in LOOKUP; during a refill it just cancels.
  assign cap = ~bus.stall &
               (ready | (bus.flush & (state == LOOKUP)));

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= LOOKUP;
    else      state <= state_nx;
  end

  // Request register and the cancel mark left by a flush.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_pc    <= '0;
      req_valid <= 1'b0;
      cancel    <= 1'b0;
    end else if (cap) begin
      req_pc    <= bus.PC;
      req_valid <= bus.pipeline_valid;
      cancel    <= 1'b0;
    end else if (bus.flush) begin
      cancel    <= 1'b1;
    end
  end

  // Line valid bits; set when a refill lands.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      valid      <= '0;
    else if (fill) valid[idx] <= 1'b1;
  end

  // Tag and data storage, written by the refill handshake.
  always_ff @(posedge clk) begin
    if (fill) begin
      tag_arr[idx] <= tag;
      for (int w = 0; w < LINE_WORDS; w++)
        data_arr[idx][w] <= bus.data_from_mem[w*WORD +: WORD];
    end
  end

  // Next state and outputs.
  always_comb begin
    state_nx  = state;
    ready     = 1'b1;
    inst      = NOP_INST;
    mem_valid = 1'b0;
    unique case (state)
      LOOKUP: begin
        if (live) begin
          ready = hit;
          if (hit) inst = word;
        end
        if (live & ~hit & ~bus.flush) state_nx = MISS;
      end
      MISS: begin
        ready     = 1'b0;
        mem_valid = 1'b1;
        if (bus.memory_ready) state_nx = REFILL;
      end
      REFILL: begin
        if (~cancel)    inst     = word;
        if (~bus.stall) state_nx = LOOKUP;
      end
      default: state_nx = LOOKUP;
    endcase
  end

  assign bus.load_addr      = {req_pc[WORD-1:OFF_W], {OFF_W{1'b0}}};
  assign bus.memory_valid   = mem_valid;
  assign bus.pipeline_ready = ready;
  assign bus.inst           = inst;
endmodule

// File: tb/tb_icache_dm_fetch.sv
// Bench for icache_dm_fetch: directed vectors, flush/reset
// sequences, and a random run against a set/tag model.
module tb_icache_dm_fetch;
  localparam logic [31:0] NOP = 32'h0340_0000;
  localparam logic H = 1'b1;
  localparam logic L = 1'b0;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  icache_dm_fetch_if bus ();

  icache_dm_fetch dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mw(input logic [31:0] a);
    return a * 32'h9E37_79B1 + 32'h1234_5678;
  endfunction

  function automatic logic [127:0] line_of(input logic [31:0] a);
    logic [127:0] l;
    logic [31:0]  base;
    base = {a[31:4], 4'b0};
    for (int w = 0; w < 4; w++)
      l[w*32 +: 32] = mw(base + 32'(w * 4));
    return l;
  endfunction

  assign bus.data_from_mem = line_of(bus.load_addr);

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic [31:0] pc, input logic pv,
                     input logic st, input logic fl,
                     input logic mr);
    bus.PC             = pc;
    bus.pipeline_valid = pv;
    bus.stall          = st;
    bus.flush          = fl;
    bus.memory_ready   = mr;
  endtask

  typedef struct {
    logic [31:0] pc;
    logic        pv, st, mr;
    logic        pr, mv;
    logic [31:0] inst, la;
  } vec_t;

  vec_t v[18];

  // random-phase model state
  bit          m_valid[64];
  logic [21:0] m_tag[64];
  int          exp_miss, dut_miss;

  initial begin
    logic [31:0] pc, req_pc;
    logic        pv, req_v, have_req, st, acc, mv_seen, mr;
    int          dly;

    v[0]  = '{32'h000, H, L, L, L, L, NOP, 32'h0};
    v[1]  = '{32'h000, H, L, L, L, H, NOP, 32'h0};
    v[2]  = '{32'h000, H, L, H, H, L, mw(32'h0), 32'h0};
    v[3]  = '{32'h004, H, L, L, H, L, mw(32'h4), 32'h0};
    v[4]  = '{32'h008, H, L, L, H, L, mw(32'h8), 32'h0};
    v[5]  = '{32'h00C, H, L, L, H, L, mw(32'hC), 32'h0};
    v[6]  = '{32'h004, H, L, L, H, L, mw(32'h4), 32'h0};
    v[7]  = '{32'h008, H, H, L, H, L, mw(32'h4), 32'h0};
    v[8]  = '{32'h200, H, H, L, H, L, mw(32'h4), 32'h0};
    v[9]  = '{32'h300, H, H, L, H, L, mw(32'h4), 32'h0};
    v[10] = '{32'h008, H, L, L, H, L, mw(32'h8), 32'h0};
    v[11] = '{32'h400, H, L, L, L, L, NOP, 32'h0};
    v[12] = '{32'h400, H, L, L, L, H, NOP, 32'h400};
    v[13] = '{32'h400, H, L, H, H, L, mw(32'h400), 32'h0};
    v[14] = '{32'h000, H, L, L, L, L, NOP, 32'h0};
    v[15] = '{32'h000, H, L, L, L, H, NOP, 32'h0};
    v[16] = '{32'h000, H, L, H, H, L, mw(32'h0), 32'h0};
    v[17] = '{32'h000, L, L, L, H, L, NOP, 32'h0};

    drv(32'h0, H, L, L, L);
    tick();
    tick();
    chk("rst_ready", 32'(bus.pipeline_ready), 32'd1);
    chk("rst_inst", bus.inst, NOP);
    chk("rst_mvalid", 32'(bus.memory_valid), 32'd0);
    chk("rst_laddr", bus.load_addr, 32'h0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 18; i++) begin
      drv(v[i].pc, v[i].pv, v[i].st, L, v[i].mr);
      tick();
      chk($sformatf("vec%0d_ready", i),
          32'(bus.pipeline_ready), 32'(v[i].pr));
      chk($sformatf("vec%0d_inst", i), bus.inst, v[i].inst);
      chk($sformatf("vec%0d_mvalid", i),
          32'(bus.memory_valid), 32'(v[i].mv));
      if (v[i].mv)
        chk($sformatf("vec%0d_laddr", i), bus.load_addr, v[i].la);
    end

    // flush while a refill is outstanding
    drv(32'h020, H, L, L, L);
    tick();
    chk("fl_miss_ready", 32'(bus.pipeline_ready), 32'd0);
    tick();
    chk("fl_mv", 32'(bus.memory_valid), 32'd1);
    chk("fl_la", bus.load_addr, 32'h20);
    drv(32'h100, H, L, H, L);
    tick();
    chk("fl_mv_held", 32'(bus.memory_valid), 32'd1);
    chk("fl_la_held", bus.load_addr, 32'h20);
    drv(32'h100, H, L, L, H);
    tick();
    chk("fl_refill_ready", 32'(bus.pipeline_ready), 32'd1);
    chk("fl_refill_nop", bus.inst, NOP);
    drv(32'h100, H, L, L, L);
    tick();
    chk("fl_tgt_miss", 32'(bus.pipeline_ready), 32'd0);
    tick();
    chk("fl_tgt_mv", 32'(bus.memory_valid), 32'd1);
    chk("fl_tgt_la", bus.load_addr, 32'h100);
    drv(32'h100, H, L, L, H);
    tick();
    chk("fl_tgt_inst", bus.inst, mw(32'h100));
    drv(32'h024, H, L, L, L);
    tick();
    chk("fl_line_kept_rdy", 32'(bus.pipeline_ready), 32'd1);
    chk("fl_line_kept", bus.inst, mw(32'h24));

    // reset in the middle of a miss
    drv(32'h800, H, L, L, L);
    tick();
    tick();
    chk("rm_mv", 32'(bus.memory_valid), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("rm_mv_drop", 32'(bus.memory_valid), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    drv(32'h000, H, L, L, L);
    tick();
    chk("rm_miss0", 32'(bus.pipeline_ready), 32'd0);
    tick();
    chk("rm_mv0", 32'(bus.memory_valid), 32'd1);
    chk("rm_la0", bus.load_addr, 32'h0);
    drv(32'h000, H, L, L, H);
    tick();
    chk("rm_inst0", bus.inst, mw(32'h0));

    // random run against set/tag model
    rst = 1'b0;
    drv(32'h0, L, L, L, L);
    for (int s = 0; s < 64; s++) m_valid[s] = 1'b0;
    exp_miss = 0;
    dut_miss = 0;
    have_req = 1'b0;
    req_pc   = '0;
    req_v    = 1'b0;
    mv_seen  = 1'b0;
    dly      = 0;
    @(negedge clk);
    rst = 1'b1;
    pc = ($urandom_range(0, 2) << 10) | ($urandom_range(0, 3) << 4)
       | ($urandom_range(0, 3) << 2);
    pv = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      if (have_req && bus.pipeline_ready)
        chk("rnd_inst", bus.inst, req_v ? mw(req_pc) : NOP);
      mr = 1'b0;
      if (bus.memory_valid) begin
        if (!mv_seen) begin
          mv_seen = 1'b1;
          dut_miss++;
          chk("rnd_la", bus.load_addr, {req_pc[31:4], 4'b0});
          dly = $urandom_range(0, 3);
        end
        mr = (dly == 0);
        if (dly > 0) dly--;
      end else begin
        mv_seen = 1'b0;
      end
      st  = (c < 2980) && ($urandom_range(0, 3) == 0);
      acc = bus.pipeline_ready && !st;
      if (acc) begin
        have_req = 1'b1;
        req_pc   = pc;
        req_v    = pv;
        if (pv) begin
          if (!(m_valid[pc[9:4]] && m_tag[pc[9:4]] == pc[31:10]))
            exp_miss++;
          m_valid[pc[9:4]] = 1'b1;
          m_tag[pc[9:4]]   = pc[31:10];
        end
      end
      drv(pc, pv, st, L, mr);
      tick();
      if (acc) begin
        pc = ($urandom_range(0, 2) << 10)
           | ($urandom_range(0, 3) << 4)
           | ($urandom_range(0, 3) << 2);
        pv = (c < 2980) && ($urandom_range(0, 7) != 0);
      end
    end
    chk("rnd_miss_count", 32'(dut_miss), 32'(exp_miss));
    chk("rnd_idle_mv", 32'(bus.memory_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
